// File: rtl/fft_half_merge_serializer.sv
// Buffers one frame of lo/hi butterfly pairs and replays it as a natural-order bin stream.
// Fill and drain alternate; input and output are never active in the same cycle.
module fft_half_merge_serializer #(
    parameter int SIZE_BUFFER   = 1,
    parameter int SIZE_OUT_DATA = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [SIZE_OUT_DATA-1:0] in_lo_i,
    input  logic [SIZE_OUT_DATA-1:0] in_lo_q,
    input  logic [SIZE_OUT_DATA-1:0] in_hi_i,
    input  logic [SIZE_OUT_DATA-1:0] in_hi_q,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [SIZE_OUT_DATA-1:0] out_i,
    output logic [SIZE_OUT_DATA-1:0] out_q,
    output logic [SIZE_BUFFER-1:0]   out_index,
    output logic                     out_last,
    output logic                     frame_done
);

    localparam int NFFT = 1 << SIZE_BUFFER;
    localparam logic [SIZE_BUFFER-1:0] WR_LAST = SIZE_BUFFER'(NFFT / 2 - 1);
    localparam logic [SIZE_BUFFER-1:0] HI_BASE = SIZE_BUFFER'(NFFT / 2);
    localparam logic [SIZE_BUFFER-1:0] RD_LAST = SIZE_BUFFER'(NFFT - 1);

    localparam logic [0:0] ST_FILL  = 1'b0;
    localparam logic [0:0] ST_DRAIN = 1'b1;

    logic [0:0]                   state;
    logic [SIZE_BUFFER-1:0]       wr;
    logic [SIZE_BUFFER-1:0]       rd;
    logic [2*SIZE_OUT_DATA-1:0]   mem [NFFT];
    logic [2*SIZE_OUT_DATA-1:0]   rd_word;
    logic                         accept;
    logic                         xfer;

    assign in_ready  = (state == ST_FILL);
    assign out_valid = (state == ST_DRAIN);
    assign accept    = in_valid & in_ready;
    assign xfer      = out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_FILL;
            wr         <= '0;
            rd         <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (accept) begin
                if (wr == WR_LAST) begin
                    wr    <= '0;
                    state <= ST_DRAIN;
                end else begin
                    wr <= wr + SIZE_BUFFER'(1);
                end
            end
            if (xfer) begin
                if (rd == RD_LAST) begin
                    rd         <= '0;
                    state      <= ST_FILL;
                    frame_done <= 1'b1;
                end else begin
                    rd <= rd + SIZE_BUFFER'(1);
                end
            end
        end
    end

    // Storage is deliberately not reset; every entry is rewritten before it is read.
    // wr stays below NFFT/2, so OR-ing in the half offset equals wr + NFFT/2.
    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wr]           <= {in_lo_i, in_lo_q};
            mem[wr | HI_BASE] <= {in_hi_i, in_hi_q};
        end
    end

    assign rd_word   = mem[rd];
    assign out_i     = rd_word[2*SIZE_OUT_DATA-1:SIZE_OUT_DATA];
    assign out_q     = rd_word[SIZE_OUT_DATA-1:0];
    assign out_index = rd;
    assign out_last  = (state == ST_DRAIN) && (rd == RD_LAST);

endmodule

// File: tb/tb_fft_half_merge_serializer.sv
// Scoreboard bench: frames are modelled as "all lo bins then all hi bins" and compared
// against the DUT stream by an independent negedge monitor.
module tb_fft_half_merge_serializer;

    localparam int SB   = 3;
    localparam int W    = 16;
    localparam int NFFT = 1 << SB;
    localparam int HALF = NFFT / 2;

    typedef struct {
        logic [W-1:0] i;
        logic [W-1:0] q;
        int           idx;
        bit           last;
    } bin_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic          in_valid, in_ready, out_valid, out_ready, out_last, frame_done;
    logic [W-1:0]  in_lo_i, in_lo_q, in_hi_i, in_hi_q, out_i, out_q;
    logic [SB-1:0] out_index;

    logic          b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_last, b_frame_done;
    logic [W-1:0]  b_lo_i, b_lo_q, b_hi_i, b_hi_q, b_out_i, b_out_q;
    logic [0:0]    b_out_index;

    fft_half_merge_serializer #(.SIZE_BUFFER(SB), .SIZE_OUT_DATA(W)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_lo_i(in_lo_i), .in_lo_q(in_lo_q), .in_hi_i(in_hi_i), .in_hi_q(in_hi_q),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_i(out_i), .out_q(out_q), .out_index(out_index),
        .out_last(out_last), .frame_done(frame_done)
    );

    fft_half_merge_serializer #(.SIZE_BUFFER(1), .SIZE_OUT_DATA(W)) dut_b (
        .clk(clk), .reset(reset),
        .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_lo_i(b_lo_i), .in_lo_q(b_lo_q), .in_hi_i(b_hi_i), .in_hi_q(b_hi_q),
        .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_i(b_out_i), .out_q(b_out_q), .out_index(b_out_index),
        .out_last(b_out_last), .frame_done(b_frame_done)
    );

    int   n_cmp  = 0;
    int   n_fail = 0;
    bin_t exp_q[$];
    bit   done_exp = 0;
    bit   mon_en   = 0;
    int   rdy_mode = 0;

    logic [W-1:0] fr_lo_i [HALF];
    logic [W-1:0] fr_lo_q [HALF];
    logic [W-1:0] fr_hi_i [HALF];
    logic [W-1:0] fr_hi_q [HALF];

    task automatic chk(input string name, input longint act, input longint req);
        n_cmp++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Expected stream: bins 0..HALF-1 are the lo values, HALF..NFFT-1 the hi values.
    task automatic push_frame();
        bin_t b;
        for (int n = 0; n < NFFT; n++) begin
            b.i    = (n < HALF) ? fr_lo_i[n] : fr_hi_i[n - HALF];
            b.q    = (n < HALF) ? fr_lo_q[n] : fr_hi_q[n - HALF];
            b.idx  = n;
            b.last = (n == NFFT - 1);
            exp_q.push_back(b);
        end
    endtask

    task automatic send_beat(input int k);
        in_lo_i  = fr_lo_i[k];
        in_lo_q  = fr_lo_q[k];
        in_hi_i  = fr_hi_i[k];
        in_hi_q  = fr_hi_q[k];
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // gap_mode: 0 none, 1 three idle cycles between beats 1 and 2, 2 random idles
    task automatic send_frame(input int gap_mode, input int nbeats);
        for (int k = 0; k < nbeats; k++) begin
            if (gap_mode == 1 && k == 2) idle(3);
            if (gap_mode == 2) idle($urandom_range(0, 2));
            send_beat(k);
        end
        if (nbeats == HALF) push_frame();
    endtask

    task automatic wait_drain(input bit junk);
        for (int c = 0; c < 400 && exp_q.size() != 0; c++) begin
            if (junk) begin
                in_valid = 1'b1;
                in_lo_i  = W'($urandom);
                in_lo_q  = W'($urandom);
                in_hi_i  = W'($urandom);
                in_hi_q  = W'($urandom);
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL drain_timeout: %0d bins left, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic do_reset(input int n);
        reset    = 1'b1;
        in_valid = 1'b0;
        exp_q.delete();
        done_exp = 0;
        repeat (n) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic fill_pattern(input int kind);
        for (int k = 0; k < HALF; k++) begin
            case (kind)
                0: begin
                    fr_lo_i[k] = W'(k);        fr_lo_q[k] = W'(-k);
                    fr_hi_i[k] = W'(100 + k);  fr_hi_q[k] = W'(-(100 + k));
                end
                1: begin
                    fr_lo_i[k] = W'(16'h7FFF - k); fr_lo_q[k] = ~W'(16'h7FFF - k);
                    fr_hi_i[k] = W'(16'h8000 + k); fr_hi_q[k] = ~W'(16'h8000 + k);
                end
                default: begin
                    fr_lo_i[k] = W'($urandom); fr_lo_q[k] = W'($urandom);
                    fr_hi_i[k] = W'($urandom); fr_hi_q[k] = W'($urandom);
                end
            endcase
        end
    endtask

    initial begin : ready_gen
        int ph = 0;
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                1:       out_ready = (ph % 3 == 0);
                2:       out_ready = ($urandom_range(0, 2) != 0);
                default: out_ready = 1'b1;
            endcase
            ph++;
        end
    end

    always @(negedge clk) begin
        if (mon_en && !reset) begin
            chk("out_valid", out_valid, exp_q.size() != 0);
            chk("in_ready", in_ready, exp_q.size() == 0);
            chk("frame_done", frame_done, done_exp);
            done_exp = 0;
            if (out_valid && exp_q.size() != 0) begin
                chk("out_i", out_i, exp_q[0].i);
                chk("out_q", out_q, exp_q[0].q);
                chk("out_index", out_index, exp_q[0].idx);
                chk("out_last", out_last, exp_q[0].last);
                if (out_ready) begin
                    done_exp = exp_q[0].last;
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        reset = 1'b1;
        in_valid = 1'b0;
        in_lo_i = '0; in_lo_q = '0; in_hi_i = '0; in_hi_q = '0;
        b_in_valid = 1'b0; b_out_ready = 1'b0;
        b_lo_i = '0; b_lo_q = '0; b_hi_i = '0; b_hi_q = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_out_index", out_index, 0);
        chk("rst_frame_done", frame_done, 0);
        reset  = 1'b0;
        mon_en = 1;

        // basic frame, then the same frame with a gap
        fill_pattern(0);
        rdy_mode = 0;
        send_frame(0, HALF);
        wait_drain(0);
        send_frame(1, HALF);
        wait_drain(0);

        // backpressure with junk input during drain
        rdy_mode = 1;
        send_frame(0, HALF);
        wait_drain(1);

        // back-to-back extreme values, sent right after frame_done
        fill_pattern(1);
        send_frame(0, HALF);
        wait_drain(1);

        // reset after 2 beats, then a full frame
        rdy_mode = 0;
        fill_pattern(2);
        send_frame(0, 2);
        do_reset(2);
        fill_pattern(2);
        send_frame(0, HALF);
        wait_drain(0);

        // reset after 3 bins drained
        fill_pattern(2);
        send_frame(0, HALF);
        for (int c = 0; c < 50 && exp_q.size() > NFFT - 3; c++) begin
            @(posedge clk);
            #1;
        end
        do_reset(1);
        fill_pattern(0);
        send_frame(0, HALF);
        wait_drain(0);

        // randomized frames
        rdy_mode = 2;
        for (int f = 0; f < 20; f++) begin
            fill_pattern(2);
            send_frame(2, HALF);
            wait_drain($urandom_range(0, 1) != 0);
            idle($urandom_range(0, 2));
        end
        rdy_mode = 0;
        idle(3);

        // NFFT=2 instance: one beat per frame
        b_lo_i = 16'd5; b_lo_q = 16'd6; b_hi_i = 16'd7; b_hi_q = 16'd8;
        b_in_valid = 1'b1;
        @(posedge clk);
        #1;
        b_in_valid = 1'b0;
        chk("b_out_valid0", b_out_valid, 1);
        chk("b_in_ready0", b_in_ready, 0);
        chk("b_out_i0", b_out_i, 5);
        chk("b_out_q0", b_out_q, 6);
        chk("b_out_index0", b_out_index, 0);
        chk("b_out_last0", b_out_last, 0);
        b_out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("b_out_i1", b_out_i, 7);
        chk("b_out_q1", b_out_q, 8);
        chk("b_out_index1", b_out_index, 1);
        chk("b_out_last1", b_out_last, 1);
        @(posedge clk);
        #1;
        b_out_ready = 1'b0;
        chk("b_frame_done", b_frame_done, 1);
        chk("b_out_valid_end", b_out_valid, 0);
        chk("b_in_ready_end", b_in_ready, 1);
        @(posedge clk);
        #1;
        chk("b_frame_done_width", b_frame_done, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/fft_half_merge_serializer.md
# fft_half_merge_serializer

Output stage directly downstream of the two-sub-FFT butterfly interconnect. That stage delivers, per valid beat k (k = 0..NFFT/2-1), both butterfly results in parallel:
- lo: X[k] = E[k] + W^k·O[k]
- hi: X[k+NFFT/2] = E[k] − W^k·O[k]

This block buffers one full frame, then emits the NFFT bins as a single natural-order stream (X[0]..X[NFFT-1]) with a valid/ready handshake. Its `frame_done` pulse is the "multiply done" acknowledge returned to the interconnect.

## Interface
Parameters:
- SIZE_BUFFER, 1, log2(NFFT); NFFT = 1 << SIZE_BUFFER.
- SIZE_OUT_DATA, 16, width of each I/Q component, two's complement.

Ports (reset is synchronous, active-high; clock is clk):
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  lo/hi pair present this cycle.
- in_ready  out  1  block accepts a pair this cycle.
- in_lo_i, in_lo_q  in  SIZE_OUT_DATA  bin k.
- in_hi_i, in_hi_q  in  SIZE_OUT_DATA  bin k+NFFT/2.
- out_valid  out  1  out_* carry a valid bin.
- out_ready  in  1  downstream accepts the bin.
- out_i, out_q  out  SIZE_OUT_DATA  bin data.
- out_index  out  SIZE_BUFFER  bin number of current output.
- out_last  out  1  high with bin NFFT-1.
- frame_done  out  1  one-cycle pulse after the last bin is transferred.

## Operation
- Storage: NFFT x (2·SIZE_OUT_DATA) register array, written synchronously and read asynchronously.
- State machine, 2 states:
  - FILL: in_ready=1, out_valid=0.
    - On each accept (in_valid & in_ready): mem[wr] <= lo, mem[wr + NFFT/2] <= hi, wr <= wr+1.
    - Accepting beat wr == NFFT/2-1 moves to DRAIN next cycle and clears wr.
  - DRAIN: in_ready=0, out_valid=1, out_i/out_q = mem[rd], out_index = rd, out_last = (rd == NFFT-1).
    - On each transfer (out_valid & out_ready): rd <= rd+1.
    - The transfer at rd == NFFT-1 clears rd, returns to FILL and sets frame_done=1 for the next cycle only.
- Beats are written in arrival order. Bin index is implied by the beat count; there is no index input.
- in_valid low during FILL holds wr, so gaps are allowed anywhere in the frame.
- in_valid asserted during DRAIN is ignored: no write, and wr stays 0.
- out_ready low during DRAIN holds rd and all out_* stable (AXI-style; valid never drops before transfer).
- Data passes through bit-exact: no scaling, rounding or sign extension.
- Counters: wr and rd are SIZE_BUFFER bits wide, so SIZE_BUFFER=1 works (wr terminal value 0, one beat per frame).

## Timing
- Reset values: state FILL, wr=0, rd=0, in_ready=1, out_valid=0, out_last=0, out_index=0, frame_done=0. out_i/out_q are don't-care while out_valid=0. Buffer contents are not cleared.
- Reset in the middle of a frame discards the partial frame; the next accepted beat is bin 0.
- Latency: out_valid rises the cycle after the last pair is accepted; X[0] is presented that cycle.
- With out_ready held high, a frame occupies NFFT/2 fill cycles plus NFFT drain cycles.
- in_ready rises the cycle after the last output transfer, coincident with frame_done. Input and output are never active in the same cycle.
- frame_done is exactly one cycle wide per frame and never asserts during reset.

## Test plan
- Basic frame, NFFT=8, SIZE_OUT_DATA=16, out_ready=1. Send 4 pairs: lo_i=k, lo_q=−k, hi_i=100+k, hi_q=−(100+k). Required:
  - out_valid rises the cycle after beat 3 is accepted.
  - out_i sequence 0,1,2,3,100,101,102,103; out_q is the negation of out_i.
  - out_index 0..7; out_last only at index 7; frame_done one cycle later; in_ready=1 that same cycle.
- Input gaps: same frame with in_valid low for 3 cycles between beats 1 and 2. Output identical; in_ready stays 1 throughout FILL.
- Backpressure: toggle out_ready 1,0,0,1,... during DRAIN. Each bin is held stable until it is transferred; no bin is duplicated or skipped; in_valid=1 with junk data during DRAIN is not written.
- Back-to-back frames: a second frame with lo=0x7FFF−k, hi=0x8000+k is sent immediately after frame_done. Sign/extreme values pass bit-exact, and the frame-1 data never reappears.
- Reset mid-frame: assert reset after 2 beats (and separately after 3 bins drained), then send a full frame. The output is exactly the new frame starting at index 0, with no frame_done from the aborted frame.
- SIZE_BUFFER=1 case: lo=(5,6), hi=(7,8). Output is (5,6) then (7,8), out_last on the second, then frame_done.
